// File: rtl/pop_scan_sequencer.sv
// pop_scan_sequencer: Ramsey free-precession scan driver for the POP timing core.
// Counts complete pump cycles per scan point, then bumps the free-precession interval.
module pop_scan_sequencer #(
    parameter int WIDTH           = 16,
    parameter int CYCLES_PER_STEP = 100,
    parameter int NUM_STEPS       = 50,
    parameter int STEP_PULSE_LEN  = 4,
    parameter int TIMEOUT_WIDTH   = 20
) (
    input  logic             clk_2M5,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pump,
    output logic             load_defaults,
    output logic             freeprecess_plus,
    output logic             scan_active,
    output logic             cycle_strobe,
    output logic [WIDTH-1:0] step_index,
    output logic [WIDTH-1:0] cycle_index,
    output logic             done,
    output logic             timeout_err
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SYNC, S_RUN, S_STEP, S_DONE} state_t;

    localparam logic [WIDTH-1:0] LAST_CYCLE = WIDTH'(CYCLES_PER_STEP - 1);
    localparam logic [WIDTH-1:0] LAST_STEP  = WIDTH'(NUM_STEPS - 1);
    localparam logic [WIDTH-1:0] PULSE_LEN  = WIDTH'(STEP_PULSE_LEN);
    localparam logic [WIDTH-1:0] STEP_END   = WIDTH'(2 * STEP_PULSE_LEN - 1);
    localparam logic [WIDTH-1:0] LOAD_END   = WIDTH'(1);

    state_t                   r_state, w_next;
    logic                     r_pump_q, r_pump_q2, r_strobe, r_timeout_err;
    logic [WIDTH-1:0]         r_step, r_cycle, r_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_wd, w_wd_inc;
    logic                     w_edge, w_watch, w_timeout, w_start, w_step_adv;

    assign w_edge     = r_pump_q & ~r_pump_q2;
    assign w_watch    = (r_state == S_SYNC) || (r_state == S_RUN);
    assign w_wd_inc   = r_wd + 1'b1;
    // Fire as the watchdog reaches all-ones, so the scan never sits on a saturated count.
    assign w_timeout  = w_watch && !w_edge && (&w_wd_inc);
    assign w_start    = (r_state == S_IDLE || r_state == S_DONE) && w_next == S_LOAD;
    assign w_step_adv = r_state == S_STEP && w_next == S_SYNC;

    always_ff @(posedge clk_2M5 or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort || w_timeout) w_next = S_IDLE;
        else begin
            case (r_state)
                S_IDLE, S_DONE: w_next = start ? S_LOAD : r_state;
                S_LOAD:         w_next = (r_cnt == LOAD_END) ? S_SYNC : S_LOAD;
                S_SYNC:         w_next = w_edge ? S_RUN : S_SYNC;
                S_RUN:          w_next = (w_edge && r_cycle == LAST_CYCLE) ? S_STEP : S_RUN;
                S_STEP:         w_next = (r_step == LAST_STEP) ? S_DONE :
                                         (r_cnt == STEP_END) ? S_SYNC : S_STEP;
                default:        w_next = S_IDLE;
            endcase
        end
    end

    // cycle_index advances the clock after its strobe so the logger sees 0..N-1 alongside each pulse.
    always_ff @(posedge clk_2M5 or negedge reset) begin
        if (!reset) begin
            r_pump_q      <= 1'b0;
            r_pump_q2     <= 1'b0;
            r_strobe      <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
            r_wd          <= '0;
            r_step        <= '0;
            r_cycle       <= '0;
        end else begin
            r_pump_q      <= pump;
            r_pump_q2     <= r_pump_q;
            r_strobe      <= !abort && r_state == S_RUN && w_edge;
            r_timeout_err <= (w_timeout && !abort) ? 1'b1 : w_start ? 1'b0 : r_timeout_err;
            r_cnt         <= (w_next == r_state && (r_state == S_LOAD || r_state == S_STEP)) ?
                             r_cnt + 1'b1 : '0;
            r_wd          <= (w_watch && !w_edge) ? w_wd_inc : '0;
            r_step        <= (w_next == S_IDLE || w_start) ? '0 :
                             w_step_adv ? r_step + 1'b1 : r_step;
            r_cycle       <= (w_next == S_IDLE || w_start || w_step_adv) ? '0 :
                             (r_strobe && r_state == S_RUN) ? r_cycle + 1'b1 : r_cycle;
        end
    end

    assign load_defaults    = r_state == S_LOAD;
    assign freeprecess_plus = r_state == S_STEP && r_step != LAST_STEP && r_cnt < PULSE_LEN;
    assign scan_active      = r_state inside {S_LOAD, S_SYNC, S_RUN, S_STEP};
    assign cycle_strobe     = r_strobe;
    assign step_index       = r_step;
    assign cycle_index      = r_cycle;
    assign done             = r_state == S_DONE;
    assign timeout_err      = r_timeout_err;
endmodule
